mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have no parameters; bus widths are fixed at 32-bit address and 32-bit data.
REQ-002 The block SHALL use a single clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
REQ-003 The block SHALL provide these ports:
- in_valid  in  1  memory instruction presented
- in_ready  out  1  block idle, accepts request
- is_store  in  1  1=store, 0=load
- size  in  msize_t  MSIZE1/MSIZE2/MSIZE4
- addr  in  32  effective address
- wdata  in  32  store data, low-aligned
- dreq  out  dbus_req_t  {valid, addr, size, strobe, data}
- dresp  in  dbus_resp_t  {addr_ok, data_ok, data}
- out_valid  out  1  one-cycle completion pulse
- out_data  out  32  raw loaded word, unshifted
- out_addr  out  32  latched request address
- out_misalign  out  1  address exception flag, valid with out_valid

Function
REQ-010 The FSM SHALL have the states IDLE, REQ, WAIT and DONE.
REQ-011 in_ready SHALL equal (state==IDLE); a request SHALL be accepted only on in_valid && in_ready.
REQ-012 On accept, the block SHALL latch is_store, size, addr and wdata.
REQ-013 Misalignment is defined as MSIZE2 with addr[0]!=0, or MSIZE4 with addr[1:0]!=0.
REQ-014 On accept with a misaligned address, the FSM SHALL go IDLE->DONE with out_misalign=1 and SHALL issue no bus request.
REQ-015 On accept with an aligned address, the FSM SHALL go IDLE->REQ.
REQ-016 dreq.valid SHALL be 1 in REQ and WAIT only.
REQ-017 dreq.addr, size, strobe and data SHALL stay stable from entry to REQ until data_ok.
REQ-018 REQ transitions:
- addr_ok=1 and data_ok=1 in the same cycle -> DONE
- addr_ok=1 only -> WAIT
- neither -> stay in REQ
REQ-019 WAIT->DONE SHALL occur on data_ok; a data_ok arriving while in REQ or WAIT SHALL be captured exactly once.
REQ-020 On data_ok, dresp.data SHALL be latched into out_data; stores SHALL leave out_data at its previous value.
REQ-021 DONE SHALL assert out_valid for exactly one cycle, then return to IDLE; out_data, out_addr and out_misalign SHALL hold until the next accept.
REQ-022 Store strobes (off = addr[1:0]):
- MSIZE1: 4'b0001<<off; data = byte replicated x4
- MSIZE2: 4'b0011<<off; data = half replicated x2
- MSIZE4: 4'b1111; data = wdata
REQ-023 For loads, strobe SHALL be 4'b0000 and dreq.data SHALL be 0.
REQ-024 Minimum latency: accept in cycle N, addr_ok+data_ok in N+1, out_valid in N+2.
REQ-025 in_valid asserted outside IDLE SHALL be ignored, with no queueing.

Reset
REQ-030 While reset is asserted:
- state SHALL be IDLE and dreq SHALL be all-zero
- out_valid=0, out_misalign=0
- out_data=0, out_addr=0
REQ-031 Reset asserted mid-transaction (REQ or WAIT) SHALL abandon it immediately, dropping dreq.valid asynchronously; a data_ok arriving after release SHALL be ignored in IDLE.

Structure
REQ-040 msize_t, dbus_req_t and dbus_resp_t SHALL come from the shared common package; the FSM state enum SHALL be added to the refcpu defs package.
REQ-041 Strobe, replicated data and misalignment logic SHALL be a combinational sub-module mem_strobe_gen(size, addr[1:0], wdata -> strobe, data, misalign).

Verification
REQ-050 The bench SHALL cover these scenarios:
- LW @0x100, addr_ok and data_ok same cycle, data 0xDEADBEEF -> out_valid at N+2, out_data=0xDEADBEEF, strobe=0.
- SB @0x103, wdata 0x000000A5, addr_ok delayed 3 cycles -> dreq stable throughout, strobe=4'b1000, data=0xA5A5A5A5.
- SH @0x102, addr_ok N+1, data_ok N+4 -> WAIT for 3 cycles, strobe=4'b1100, data=0x????BEEF replicated, single out_valid.
- LW @0x101 -> no dreq.valid ever, out_valid at N+1, out_misalign=1, out_addr=0x101.
- Reset asserted while in WAIT, then stray data_ok after release -> dreq.valid=0 instantly, stays IDLE, no out_valid.
- in_valid held high across back-to-back LWs -> second accepted only after DONE, in_ready low throughout.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the data-bus memory access unit: access size, bus request/response
// structs and the access FSM state encoding.
package mem_access_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_strobe_gen.sv
// Byte-lane strobe, store-data replication and alignment check for one access,
// derived from the access size and the low two address bits.
module mem_strobe_gen
    import mem_access_pkg::*;
(
    input  msize_t      size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  strobe,
    output logic [31:0] data,
    output logic        misalign
);

    always_comb begin
        strobe   = 4'b0000;
        data     = wdata;
        misalign = 1'b0;
        case (size)
            MSIZE1: begin
                strobe = 4'b0001 << addr_lo;
                data   = {4{wdata[7:0]}};
            end
            MSIZE2: begin
                strobe   = 4'b0011 << addr_lo;
                data     = {2{wdata[15:0]}};
                misalign = addr_lo[0];
            end
            MSIZE4: begin
                strobe   = 4'b1111;
                misalign = |addr_lo;
            end
            default: begin
                strobe = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Single-outstanding load/store unit: accepts one memory instruction, drives the data
// bus through an addr_ok/data_ok handshake and reports a one-cycle completion pulse.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_store,
    input  msize_t      size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic        out_misalign
);

    mem_state_t  r_state;
    dbus_req_t   r_dreq;
    logic        r_is_store;
    logic        r_data_got;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic [31:0] r_out_addr;
    logic        r_out_misalign;

    logic [3:0]  w_strobe;
    logic [31:0] w_data;
    logic        w_misalign;
    logic        w_accept;

    mem_strobe_gen u_strobe_gen (
        .size     (size),
        .addr_lo  (addr[1:0]),
        .wdata    (wdata),
        .strobe   (w_strobe),
        .data     (w_data),
        .misalign (w_misalign)
    );

    assign in_ready     = (r_state == ST_IDLE);
    assign w_accept     = in_valid && in_ready;
    assign dreq         = r_dreq;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_addr     = r_out_addr;
    assign out_misalign = r_out_misalign;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_dreq         <= '0;
            r_is_store     <= 1'b0;
            r_data_got     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_data     <= 32'd0;
            r_out_addr     <= 32'd0;
            r_out_misalign <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_is_store     <= is_store;
                        r_data_got     <= 1'b0;
                        r_out_addr     <= addr;
                        r_out_misalign <= w_misalign;
                        if (w_misalign) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            // Request fields are frozen here and held until data_ok.
                            r_state       <= ST_REQ;
                            r_dreq.valid  <= 1'b1;
                            r_dreq.addr   <= addr;
                            r_dreq.size   <= size;
                            r_dreq.strobe <= is_store ? w_strobe : 4'b0000;
                            r_dreq.data   <= is_store ? w_data : 32'd0;
                        end
                    end
                end
                ST_REQ: begin
                    // data_ok may precede addr_ok; remember it so it is taken only once.
                    if (dresp.data_ok && !r_data_got) begin
                        r_data_got <= 1'b1;
                        if (!r_is_store) begin
                            r_out_data <= dresp.data;
                        end
                    end
                    if (dresp.addr_ok) begin
                        if (dresp.data_ok || r_data_got) begin
                            r_state      <= ST_DONE;
                            r_out_valid  <= 1'b1;
                            r_dreq.valid <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dresp.data_ok) begin
                        if (!r_is_store) begin
                            r_out_data <= dresp.data;
                        end
                        r_data_got   <= 1'b1;
                        r_state      <= ST_DONE;
                        r_out_valid  <= 1'b1;
                        r_dreq.valid <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboarded bench for mem_access: directed bus scenarios plus randomized loads/stores
// with a bench-side bus responder and a reference model of strobes, data and latency.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        is_store;
    msize_t      size;
    logic [31:0] addr;
    logic [31:0] wdata;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        out_valid;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic        out_misalign;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks;
    int          errors;
    int          cyc;
    logic [31:0] last_data;

    mem_access dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .is_store     (is_store),
        .size         (size),
        .addr         (addr),
        .wdata        (wdata),
        .dreq         (dreq),
        .dresp        (dresp),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .out_misalign (out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got pulse at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_addr", out_addr, e.addr);
                chk("out_misalign", 32'(out_misalign), 32'(e.mis));
                chk("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        ok = (in_ready === 1'b1);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready=%b expected 1", in_ready);
        end
    endtask

    // One full transaction: issue, predict, then play the bus slave with the given delays.
    task automatic do_txn(input logic t_st, input msize_t t_sz, input logic [31:0] t_a,
                          input logic [31:0] t_wd, input int t_adly, input int t_ddly,
                          input logic [31:0] t_rd);
        int          nb;
        logic        mis;
        logic [3:0]  es;
        logic [31:0] ed;
        exp_t        e;
        bit          ok;
        nb  = (t_sz == MSIZE1) ? 1 : (t_sz == MSIZE2) ? 2 : 4;
        mis = (t_a % nb) != 0;
        es  = t_st ? 4'(((1 << nb) - 1) << (t_a % 4)) : 4'b0000;
        if (!t_st)         ed = 32'd0;
        else if (nb == 1)  ed = (t_wd % 256) * 32'h01010101;
        else if (nb == 2)  ed = (t_wd % 65536) * 32'h00010001;
        else               ed = t_wd;

        wait_ready(ok);
        if (!ok) return;
        in_valid = 1'b1;
        is_store = t_st;
        size     = t_sz;
        addr     = t_a;
        wdata    = t_wd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        addr     = $urandom;
        wdata    = $urandom;

        e.addr = t_a;
        e.mis  = mis;
        if (!mis && !t_st) last_data = t_rd;
        e.data = last_data;
        e.cyc  = mis ? cyc : cyc + 1 + t_adly + t_ddly;
        q.push_back(e);

        if (mis) begin
            chk("misalign_no_dreq", 32'(dreq.valid), 32'd0);
            return;
        end
        for (int k = 0; k <= t_adly + t_ddly; k++) begin
            chk("dreq_valid", 32'(dreq.valid), 32'd1);
            chk("dreq_addr", dreq.addr, t_a);
            chk("dreq_size", 32'(dreq.size), 32'(t_sz));
            chk("dreq_strobe", 32'(dreq.strobe), 32'(es));
            chk("dreq_data", dreq.data, ed);
            chk("busy_not_ready", 32'(in_ready), 32'd0);
            dresp.addr_ok = (k == t_adly);
            dresp.data_ok = (k == t_adly + t_ddly);
            dresp.data    = dresp.data_ok ? t_rd : $urandom;
            @(posedge clk); #1;
            dresp = '0;
        end
        chk("dreq_drop", 32'(dreq.valid), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        last_data = 32'd0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        is_store  = 1'b0;
        size      = MSIZE4;
        addr      = 32'd0;
        wdata     = 32'd0;
        dresp     = '0;

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_dreq", 32'(dreq != '0), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_misalign", 32'(out_misalign), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios.
        do_txn(1'b0, MSIZE4, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
        do_txn(1'b1, MSIZE1, 32'h103, 32'h000000A5, 3, 0, 32'h0BADF00D);
        chk("store_keeps_data", out_data, 32'hDEADBEEF);
        do_txn(1'b1, MSIZE2, 32'h102, 32'h1234BEEF, 0, 3, 32'h0);
        do_txn(1'b0, MSIZE4, 32'h101, 32'h0, 0, 0, 32'h0);
        @(posedge clk); #1;

        // Back-to-back loads with in_valid held high.
        begin
            bit ok;
            exp_t e;
            wait_ready(ok);
            in_valid = 1'b1; is_store = 1'b0; size = MSIZE4; addr = 32'h200;
            @(posedge clk); #1;
            e.data = 32'h11111111; e.addr = 32'h200; e.mis = 1'b0; e.cyc = cyc + 1;
            q.push_back(e);
            last_data = 32'h11111111;
            addr = 32'h204;
            chk("b2b_ready_req", 32'(in_ready), 32'd0);
            chk("b2b_dreq_addr_held", dreq.addr, 32'h200);
            dresp.addr_ok = 1'b1; dresp.data_ok = 1'b1; dresp.data = 32'h11111111;
            @(posedge clk); #1;
            dresp = '0;
            chk("b2b_ready_done", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            chk("b2b_ready_idle", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            e.data = 32'h22222222; e.addr = 32'h204; e.mis = 1'b0; e.cyc = cyc + 1;
            q.push_back(e);
            last_data = 32'h22222222;
            chk("b2b_second_addr", dreq.addr, 32'h204);
            dresp.addr_ok = 1'b1; dresp.data_ok = 1'b1; dresp.data = 32'h22222222;
            @(posedge clk); #1;
            dresp = '0;
            @(posedge clk); #1;
        end

        // Reset while waiting for data, then a stray data_ok after release.
        begin
            bit ok;
            wait_ready(ok);
            in_valid = 1'b1; is_store = 1'b0; size = MSIZE4; addr = 32'h300;
            @(posedge clk); #1;
            in_valid = 1'b0;
            dresp.addr_ok = 1'b1;
            @(posedge clk); #1;
            dresp = '0;
            chk("wait_dreq_valid", 32'(dreq.valid), 32'd1);
            #2 reset = 1'b1;
            #1;
            chk("async_dreq_drop", 32'(dreq.valid), 32'd0);
            chk("async_in_ready", 32'(in_ready), 32'd1);
            chk("async_out_data", out_data, 32'd0);
            chk("async_out_addr", out_addr, 32'd0);
            @(posedge clk); #1;
            reset = 1'b0;
            last_data = 32'd0;
            dresp.data_ok = 1'b1; dresp.data = 32'hBAD0BAD0;
            @(posedge clk); #1;
            dresp = '0;
            chk("stray_ready", 32'(in_ready), 32'd1);
            chk("stray_out_data", out_data, 32'd0);
            @(posedge clk); #1;
        end

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_txn(1'($urandom_range(0, 1)), msize_t'($urandom_range(0, 2)), a, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("all_completions_seen", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
